// File: rtl/line_seq_pkg.sv
// Shared types, geometry constants and helpers for the line frame sequencer.
// Optional vertex clipping is enabled by defining LINE_SEQ_CLIP_EN.
package line_seq_pkg;

    localparam int unsigned P_COORD_W  = 16;
    localparam int unsigned P_SCREEN_W = 640;
    localparam int unsigned P_SCREEN_H = 480;
    localparam int unsigned P_X_L      = 250;
    localparam int unsigned P_X_R      = 400;
    localparam int unsigned P_Y_C      = 200;
    localparam int unsigned P_HALF_H   = 50;
    localparam int unsigned OVR_W      = 8;
    localparam int unsigned IDX_W      = 2;

    typedef logic signed [P_COORD_W-1:0] coord_t;

    typedef enum logic {
        SHAPE_LINE = 1'b0,
        SHAPE_QUAD = 1'b1
    } shape_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_CLR,
        S_WAIT_RDY,
        S_ISSUE,
        S_GAP,
        S_DONE
    } state_t;

    typedef struct packed {
        coord_t x0;
        coord_t y0;
        coord_t x1;
        coord_t y1;
    } seg_t;

    localparam coord_t X_L    = coord_t'(P_X_L);
    localparam coord_t X_R    = coord_t'(P_X_R);
    localparam coord_t Y_C    = coord_t'(P_Y_C);
    localparam coord_t HALF_H = coord_t'(P_HALF_H);

    localparam logic [IDX_W-1:0] LAST_IDX_LINE = 2'd0;
    localparam logic [IDX_W-1:0] LAST_IDX_QUAD = 2'd3;

    function automatic logic [IDX_W-1:0] last_idx(input shape_t s);
        return (s == SHAPE_QUAD) ? LAST_IDX_QUAD : LAST_IDX_LINE;
    endfunction

    // Signed clamp of a coordinate into [0, hi].
    function automatic coord_t clamp(input coord_t v, input int unsigned hi);
        if (v < coord_t'(0)) return coord_t'(0);
        if (v > coord_t'(hi)) return coord_t'(hi);
        return v;
    endfunction

endpackage

// File: rtl/seg_vertex_gen.sv
// Combinational segment endpoint generator: (shape, index, tilt) -> segment.
// Clamps every vertex to the screen when LINE_SEQ_CLIP_EN is defined.
module seg_vertex_gen
    import line_seq_pkg::*;
(
    input  shape_t           i_shape,
    input  logic [IDX_W-1:0] i_idx,
    input  coord_t           i_tilt,
    output seg_t             o_seg
);

    coord_t y_lt, y_rt, y_rb, y_lb;
    seg_t   raw;

    // Quad corners: left side moves with +tilt, right side with -tilt.
    always_comb begin
        y_lt = Y_C + i_tilt - HALF_H;
        y_rt = Y_C - i_tilt - HALF_H;
        y_rb = Y_C - i_tilt + HALF_H;
        y_lb = Y_C + i_tilt + HALF_H;
        raw  = '0;
        if (i_shape == SHAPE_LINE) begin
            raw = '{X_L, Y_C + i_tilt, X_R, Y_C - i_tilt};
        end else begin
            case (i_idx)
                2'd0:    raw = '{X_L, y_lt, X_R, y_rt};
                2'd1:    raw = '{X_R, y_rt, X_R, y_rb};
                2'd2:    raw = '{X_R, y_rb, X_L, y_lb};
                default: raw = '{X_L, y_lb, X_L, y_lt};
            endcase
        end
    end

`ifdef LINE_SEQ_CLIP_EN
    always_comb begin
        o_seg.x0 = clamp(raw.x0, P_SCREEN_W - 1);
        o_seg.y0 = clamp(raw.y0, P_SCREEN_H - 1);
        o_seg.x1 = clamp(raw.x1, P_SCREEN_W - 1);
        o_seg.y1 = clamp(raw.y1, P_SCREEN_H - 1);
    end
`else
    assign o_seg = raw;
`endif

endmodule

// File: rtl/line_frame_sequencer.sv
// Frame-level controller: on each frame tick clears the buffer, then hands the
// shape's segments to the rasterizer one at a time. Clipping via LINE_SEQ_CLIP_EN.
module line_frame_sequencer
    import line_seq_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_frame_tick,
    input  logic                 i_shape,
    input  logic [P_COORD_W-1:0] i_tilt,
    input  logic                 i_ready,
    output logic                 o_clear,
    output logic                 o_seg_valid,
    output logic [P_COORD_W-1:0] o_x0,
    output logic [P_COORD_W-1:0] o_y0,
    output logic [P_COORD_W-1:0] o_x1,
    output logic [P_COORD_W-1:0] o_y1,
    output logic [IDX_W-1:0]     o_seg_idx,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic [OVR_W-1:0]     o_overrun_cnt
);

    state_t           state_q, state_d;
    logic             tick_q;
    logic             pend_q, pend_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    coord_t           tilt_q, tilt_d;
    shape_t           shape_q, shape_d;
    seg_t             seg_q, gen_seg;
    logic             clear_q, valid_q, busy_q, done_q;
    logic             tick_edge;

    assign tick_edge = i_frame_tick & ~tick_q;

    seg_vertex_gen u_gen (
        .i_shape (shape_q),
        .i_idx   (idx_q),
        .i_tilt  (tilt_q),
        .o_seg   (gen_seg)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        idx_d   = idx_q;
        tilt_d  = tilt_q;
        shape_d = shape_q;
        case (state_q)
            S_IDLE: begin
                if (tick_edge || pend_q) begin
                    state_d = S_CLEAR;
                    // An edge arriving while a pending frame is consumed becomes the new pending.
                    pend_d  = pend_q && tick_edge;
                    idx_d   = '0;
                    tilt_d  = coord_t'(i_tilt);
                    shape_d = shape_t'(i_shape);
                end
            end
            S_CLEAR:    state_d = S_WAIT_CLR;
            S_WAIT_CLR: state_d = S_WAIT_RDY;
            S_WAIT_RDY: if (i_ready) state_d = S_ISSUE;
            S_ISSUE: begin
                if (i_ready) begin
                    if (idx_q == last_idx(shape_q)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GAP;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            S_GAP:   state_d = S_WAIT_RDY;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (tick_edge && (state_q != S_IDLE)) begin
            if (!pend_q) begin
                pend_d = 1'b1;
            end else if (ovr_q != '1) begin
                ovr_d = ovr_q + OVR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            tick_q  <= 1'b0;
            pend_q  <= 1'b0;
            ovr_q   <= '0;
            idx_q   <= '0;
            tilt_q  <= '0;
            shape_q <= SHAPE_LINE;
            seg_q   <= '0;
            clear_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= i_frame_tick;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            idx_q   <= idx_d;
            tilt_q  <= tilt_d;
            shape_q <= shape_d;
            clear_q <= (state_d == S_CLEAR);
            valid_q <= (state_d == S_ISSUE);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            // Coordinates are captured once per segment and held while waiting for ready.
            if ((state_d == S_ISSUE) && (state_q != S_ISSUE)) begin
                seg_q <= gen_seg;
            end
        end
    end

    assign o_clear       = clear_q;
    assign o_seg_valid   = valid_q;
    assign o_x0          = seg_q.x0;
    assign o_y0          = seg_q.y0;
    assign o_x1          = seg_q.x1;
    assign o_y1          = seg_q.y1;
    assign o_seg_idx     = idx_q;
    assign o_busy        = busy_q;
    assign o_frame_done  = done_q;
    assign o_overrun_cnt = ovr_q;

endmodule

// File: tb/tb_line_frame_sequencer.sv
// Scoreboard bench for line_frame_sequencer: expected segments are queued by the
// stimulus, a monitor compares every valid cycle and pops on each transfer.
module tb_line_frame_sequencer;

    typedef struct {
        int idx;
        int x0;
        int y0;
        int x1;
        int y1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        shape;
    logic [15:0] tilt;
    logic        ready;
    logic        o_clear, o_seg_valid, o_busy, o_frame_done;
    logic [15:0] o_x0, o_y0, o_x1, o_y1;
    logic [1:0]  o_seg_idx;
    logic [7:0]  o_overrun_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   clear_cnt = 0;
    int   done_cnt  = 0;
    int   seg_cnt   = 0;
    bit   stall_mode = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    line_frame_sequencer dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_frame_tick  (tick),
        .i_shape       (shape),
        .i_tilt        (tilt),
        .i_ready       (ready),
        .o_clear       (o_clear),
        .o_seg_valid   (o_seg_valid),
        .o_x0          (o_x0),
        .o_y0          (o_y0),
        .o_x1          (o_x1),
        .o_y1          (o_y1),
        .o_seg_idx     (o_seg_idx),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done),
        .o_overrun_cnt (o_overrun_cnt)
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_seg(input int idx, input int x0, input int y0, input int x1, input int y1);
        exp_t e;
        e.idx = idx; e.x0 = x0; e.y0 = y0; e.x1 = x1; e.y1 = y1;
        exp_q.push_back(e);
    endtask

    task automatic push_quad_t0();
        push_seg(0, 250, 150, 400, 150);
        push_seg(1, 400, 150, 400, 250);
        push_seg(2, 400, 250, 250, 250);
        push_seg(3, 250, 250, 250, 150);
    endtask

    task automatic tick_pulse();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 500 && done_cnt < target; i++) @(posedge clk);
        #1;
        check("frame_done_count", done_cnt, target);
    endtask

    // Rasterizer model: in stall mode ready stays low for 5 cycles of each valid segment.
    initial begin : ready_drv
        int stall_cnt = 0;
        ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_mode && o_seg_valid && stall_cnt < 5) begin
                ready = 1'b0;
                stall_cnt++;
            end else begin
                ready = 1'b1;
                stall_cnt = 0;
            end
        end
    end

    initial begin : monitor
        bit   prev_clear = 1'b0;
        bit   prev_done  = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_clear = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (o_clear) begin
                    clear_cnt++;
                    check("clear_one_cycle", 32'(prev_clear), 0);
                end
                if (o_frame_done) begin
                    done_cnt++;
                    check("done_one_cycle", 32'(prev_done), 0);
                end
                if (o_seg_valid) begin
                    check("clear_before_seg", clear_cnt, done_cnt + 1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_seg: got idx %0d expected none", o_seg_idx);
                    end else begin
                        e = exp_q[0];
                        check("seg_idx", 32'(o_seg_idx), e.idx);
                        check("seg_x0", $signed(o_x0), e.x0);
                        check("seg_y0", $signed(o_y0), e.y0);
                        check("seg_x1", $signed(o_x1), e.x1);
                        check("seg_y1", $signed(o_y1), e.y1);
                        if (ready) begin
                            void'(exp_q.pop_front());
                            seg_cnt++;
                        end
                    end
                end
                prev_clear = o_clear;
                prev_done  = o_frame_done;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_clear"}, 32'(o_clear), 0);
        check({tag, "_valid"}, 32'(o_seg_valid), 0);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_done"}, 32'(o_frame_done), 0);
        check({tag, "_coords"}, 32'({o_x0, o_y0} | {o_x1, o_y1}), 0);
        check({tag, "_idx"}, 32'(o_seg_idx), 0);
        check({tag, "_overrun"}, 32'(o_overrun_cnt), 0);
    endtask

    initial begin : stim
        bit hit;
        rst = 1'b1; tick = 1'b0; shape = 1'b0; tilt = 16'd0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b0;

        // 1: single line, tilt +20
        shape = 1'b0; tilt = 16'd20;
        push_seg(0, 250, 220, 400, 180);
        tick_pulse();
        wait_done(1);
        check("t1_clears", clear_cnt, 1);
        check("t1_segs", seg_cnt, 1);
        check("t1_busy_after", 32'(o_busy), 0);

        // 2: quad, tilt 0, rasterizer stalls each segment
        stall_mode = 1'b1;
        shape = 1'b1; tilt = 16'd0;
        push_quad_t0();
        tick_pulse();
        wait_done(2);
        check("t2_segs", seg_cnt, 5);

        // 3: three extra edges during a busy frame -> one pending, two overruns
        shape = 1'b0; tilt = 16'd5;
        push_seg(0, 250, 205, 400, 195);
        push_seg(0, 250, 205, 400, 195);
        repeat (4) tick_pulse();
        wait_done(3);
        wait_done(4);
        check("t3_overrun", 32'(o_overrun_cnt), 2);
        check("t3_clears", clear_cnt, 4);
        check("t3_segs", seg_cnt, 7);
        stall_mode = 1'b0;

        // 4: large negative tilt
        shape = 1'b0; tilt = -16'sd300;
`ifdef LINE_SEQ_CLIP_EN
        push_seg(0, 250, 0, 400, 479);
`else
        push_seg(0, 250, -100, 400, 500);
`endif
        tick_pulse();
        wait_done(5);
        check("t4_segs", seg_cnt, 8);

        // 6: inputs change mid-frame; only the next frame sees them
        shape = 1'b0; tilt = 16'd10;
        push_seg(0, 250, 210, 400, 190);
        tick_pulse();
        shape = 1'b1; tilt = 16'd0;
        push_quad_t0();
        wait_done(6);
        check("t6_first_segs", seg_cnt, 9);
        tick_pulse();
        wait_done(7);
        check("t6_second_segs", seg_cnt, 13);

        // 5: reset while in the gap after the first quad segment
        push_seg(0, 250, 150, 400, 150);
        tick_pulse();
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk); #1;
            hit = o_seg_valid;
        end
        check("t5_reached_issue", 32'(hit), 1);
        @(posedge clk); #1;
        check("t5_in_gap_valid", 32'(o_seg_valid), 0);
        check("t5_in_gap_busy", 32'(o_busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("t5_after_reset");
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t5_no_done", done_cnt, 7);
        check("t5_clears", clear_cnt, 8);
        check("t5_segs", seg_cnt, 14);
        check("t5_idle", 32'(o_busy), 0);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
